clk_div_gen: RTL and testbench
==============================

Name: clk_div_gen

Overview:
Synthesizable, parametrised multi-channel clock generator. It produces CH independent divided clocks, plus a one-cycle tick strobe per channel, from a single system clock. Each channel's divide ratio is runtime-programmable and changes without glitches. Start and stop requests always complete a full period. It feeds the timer, UART-baud and stimulus logic that today relies on fixed behavioural clock generation.

Parameters:
CH, 4, number of independent output channels (>=1)
DIV_W, 8, width of each channel's divide ratio
RST_DIV, 2, divide ratio loaded into every channel at reset (must be >=2 and <2^DIV_W)

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
en  input  CH  per-channel run request, level-sensitive
div  input  CH*DIV_W  per-channel divide ratio; channel i uses div[i*DIV_W +: DIV_W]
load  input  CH  per-channel one-cycle strobe that captures div for that channel
clk_out  output  CH  divided clock, registered
tick  output  CH  one-cycle pulse at every rising edge of clk_out, registered
active  output  CH  channel is in RUN or STOP state, registered

Behaviour:
- Reset (rst high at an edge) applies to all channels:
  - state=IDLE, cnt=0, act_div=RST_DIV, pend_valid=0.
  - clk_out=0, tick=0, active=0.
  - rst overrides en and load in the same cycle, including mid-period; the output drops low at once, with no drain.
- Per-channel registers: cnt (DIV_W bits), act_div, pend_div, pend_valid, state in {IDLE, RUN, STOP}. Channels are fully independent.
- A divisor D is valid when D>=2. D=0 and D=1 are invalid and hold the channel idle.
- Period shape for valid D:
  - Period is D clk cycles.
  - clk_out is high for ceil(D/2) cycles, then low for floor(D/2) cycles.
  - Example: D=5 gives 3 high, 2 low.
- Each edge in RUN or STOP computes the next count as nc = (cnt==act_div-1) ? 0 : cnt+1. Then:
  - cnt <= nc
  - clk_out <= (nc < ceil(act_div/2))
  - tick <= (nc==0)
- Wrap edge: an edge at which nc==0.
- IDLE:
  - clk_out=0, tick=0, cnt=0.
  - If en is high and act_div is valid at an edge: state<=RUN, cnt<=0, clk_out<=1, tick<=1, active<=1.
  - Latency: the first high cycle and first tick are visible in the cycle after en is sampled.
- RUN:
  - Free-running as above.
  - en low at an edge: state<=STOP. The current period continues unchanged.
- STOP:
  - Keeps counting.
  - en high again before the wrap: state<=RUN, with no phase disturbance.
  - At the wrap edge with en still low: state<=IDLE, cnt<=0, clk_out<=0, tick<=0, active<=0. The last period is always complete.
- Divisor loading:
  - In IDLE, load applies at once: act_div<=div at that edge. A start can occur from the next edge onward.
  - In RUN or STOP, load sets pend_div<=div and pend_valid<=1. A later load before the wrap overwrites it (last-write-wins).
  - At a wrap edge with pend_valid set: act_div<=pend_div and pend_valid<=0. The new period shape starts with the period that begins at that edge; clk_out and tick at that edge use the new act_div.
  - load asserted on the wrap edge itself: div bypasses pend_div and is used directly.
  - A period is never truncated or stretched mid-way, so there are no runt pulses on clk_out.
- Invalid divisor applied at a wrap edge:
  - Channel goes to IDLE with outputs low and active=0.
  - It stays IDLE until a valid divisor is loaded. If en is still high, it then restarts one edge after the load.
- en high at an edge while in IDLE with an invalid act_div: no effect.
- load and en changes on different channels in the same cycle are independent.

Test Plan:
- rst for 2 cycles, then ch0 en=1, act_div=2 -> from the next cycle clk_out[0]=1,0,1,0…, tick[0] high every 2nd cycle starting at the first high cycle, active[0]=1; other channels' outputs stay 0.
- Load ch1 div=5 in IDLE, then en[1]=1 -> clk_out[1] repeats 1,1,1,0,0; tick[1] every 5 cycles.
- Load ch2 div=4 at cnt=2 of a running div=6 period -> the current period completes (3 high, 3 low), then periods are 4 cycles (2 high, 2 low), with no runt pulse.
- Load ch2 div=3 exactly on a wrap edge -> the period starting at that edge is 3 cycles (2 high, 1 low).
- ch3 div=8, drop en at cnt=1 -> runs through cnt=7; at the wrap edge active[3]=0 and clk_out[3]=0, with exactly 4 high cycles in the final period.
  - Repeat, re-raising en at cnt=5 -> no gap, continuous 8-cycle periods.
- Load div=0, then div=1, while running -> channel idles at the next wrap and stays low with en=1; then load div=2 -> restart one cycle later.
- Assert rst mid-period on all channels -> the next cycle has all clk_out/tick/active=0 and act_div=RST_DIV. With en still high, each channel restarts with a div=2 pattern one edge after rst is released.

Source files
------------

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider.
// Each channel produces a divided clock and a tick strobe. Divisor changes are
// glitch-free. Every start and stop runs a whole number of complete periods.
module clk_div_gen #(
  parameter int unsigned CH      = 4,
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned RST_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH-1:0]         en,
  input  logic [CH*DIV_W-1:0]   div,
  input  logic [CH-1:0]         load,
  output logic [CH-1:0]         clk_out,
  output logic [CH-1:0]         tick,
  output logic [CH-1:0]         active
);

  localparam int unsigned CW = DIV_W + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] STOP = 2'd2;

  for (genvar i = 0; i < int'(CH); i++) begin : g_ch
    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] adiv_q, adiv_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             act_q, act_d;
    logic [DIV_W-1:0] div_i;
    logic [DIV_W-1:0] nc;
    logic [DIV_W-1:0] new_div;
    logic [CW-1:0]    half;

    assign div_i = div[i*DIV_W +: DIV_W];
    // Next count within the current period; zero marks the wrap edge.
    assign nc    = (cnt_q == adiv_q - DIV_W'(1)) ? '0 : cnt_q + DIV_W'(1);
    // Length of the high phase: ceil(adiv/2).
    assign half  = ({1'b0, adiv_q} + CW'(1)) >> 1;

    // Next-state, counter, divisor hand-off and output decode.
    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      adiv_d   = adiv_q;
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      clk_d    = 1'b0;
      tick_d   = 1'b0;
      new_div  = adiv_q;
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (load[i]) begin
            // A load in IDLE takes effect at once; a start can follow on the next edge.
            adiv_d = div_i;
          end else if (en[i] && (adiv_q >= DIV_W'(2))) begin
            state_d = RUN;
            clk_d   = 1'b1;
            tick_d  = 1'b1;
          end
        end
        RUN, STOP: begin
          if (nc == '0) begin
            // Wrap edge: a divisor loaded on this edge wins, then a pending one.
            if (load[i]) begin
              new_div = div_i;
            end else if (pend_v_q) begin
              new_div = pend_q;
            end
            adiv_d   = new_div;
            pend_v_d = 1'b0;
            cnt_d    = '0;
            if ((new_div < DIV_W'(2)) || ((state_q == STOP) && !en[i])) begin
              state_d = IDLE;
            end else begin
              state_d = en[i] ? RUN : STOP;
              clk_d   = 1'b1;
              tick_d  = 1'b1;
            end
          end else begin
            cnt_d   = nc;
            clk_d   = ({1'b0, nc} < half);
            state_d = en[i] ? RUN : STOP;
            if (load[i]) begin
              pend_d   = div_i;
              pend_v_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
      act_d = (state_d != IDLE);
    end

    // Channel registers with synchronous reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        adiv_q   <= DIV_W'(RST_DIV);
        pend_q   <= '0;
        pend_v_q <= 1'b0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
        act_q    <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        adiv_q   <= adiv_d;
        pend_q   <= pend_d;
        pend_v_q <= pend_v_d;
        clk_q    <= clk_d;
        tick_q   <= tick_d;
        act_q    <= act_d;
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
    assign active[i]  = act_q;
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen with hand-computed per-cycle waveforms.
module tb_clk_div_gen;

  localparam int unsigned CH    = 4;
  localparam int unsigned DIV_W = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [CH-1:0]       en;
  logic [CH*DIV_W-1:0] div;
  logic [CH-1:0]       load;
  logic [CH-1:0]       clk_out;
  logic [CH-1:0]       tick;
  logic [CH-1:0]       active;

  int n_checks = 0;
  int n_pass   = 0;

  clk_div_gen #(.CH(CH), .DIV_W(DIV_W), .RST_DIV(2)) dut (
    .clk(clk), .rst(rst), .en(en), .div(div), .load(load),
    .clk_out(clk_out), .tick(tick), .active(active)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_div(input int ch, input logic [DIV_W-1:0] v);
    div[ch*DIV_W +: DIV_W] = v;
  endtask

  task automatic chk_ch(input string tag, input int ch, input int k,
                        input string ec, input string et, input string ea);
    check($sformatf("%s clk_out k=%0d", tag, k), 32'(clk_out[ch]), 32'(ec[k] == "1"));
    check($sformatf("%s tick k=%0d", tag, k),    32'(tick[ch]),    32'(et[k] == "1"));
    check($sformatf("%s active k=%0d", tag, k),  32'(active[ch]),  32'(ea[k] == "1"));
  endtask

  task automatic wait_tick(input int ch);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (tick[ch]) seen = 1'b1;
    end
    check($sformatf("wait_tick ch%0d", ch), 32'(seen), 32'd1);
  endtask

  initial begin
    rst  = 1'b1;
    en   = '0;
    load = '0;
    div  = '0;
    step();
    step();
    check("reset clk_out", 32'(clk_out), 32'd0);
    check("reset tick",    32'(tick),    32'd0);
    check("reset active",  32'(active),  32'd0);
    rst = 1'b0;

    // ch0 with reset divisor 2
    en[0] = 1'b1;
    step();
    for (int k = 0; k < 6; k++) begin
      check($sformatf("ch0 clk_out k=%0d", k), 32'(clk_out[0]), 32'((k % 2) == 0));
      check($sformatf("ch0 tick k=%0d", k),    32'(tick[0]),    32'((k % 2) == 0));
      check($sformatf("ch0 active k=%0d", k),  32'(active[0]),  32'd1);
      check($sformatf("others idle k=%0d", k), 32'({clk_out[3:1], tick[3:1], active[3:1]}), 32'd0);
      step();
    end

    // ch1 divisor 5 loaded in IDLE
    set_div(1, 8'd5);
    load[1] = 1'b1;
    step();
    load[1] = 1'b0;
    check("ch1 no start on load", 32'(active[1]), 32'd0);
    en[1] = 1'b1;
    step();
    for (int k = 0; k < 10; k++) begin
      chk_ch("ch1 div5", 1, k, "1110011100", "1000010000", "1111111111");
      step();
    end

    // ch2: div 6, reload 4 mid-period, then 3 exactly on a wrap edge
    set_div(2, 8'd6);
    load[2] = 1'b1;
    step();
    load[2] = 1'b0;
    en[2] = 1'b1;
    step();
    for (int k = 0; k < 20; k++) begin
      chk_ch("ch2 reload", 2, k, "11100011001100110110", "10000010001000100100",
             "11111111111111111111");
      load[2] = (k == 2) || (k == 13);
      set_div(2, (k == 2) ? 8'd4 : 8'd3);
      step();
    end
    load[2] = 1'b0;

    // ch3 div 8, en dropped at cnt=1: one full final period then idle
    set_div(3, 8'd8);
    load[3] = 1'b1;
    step();
    load[3] = 1'b0;
    en[3] = 1'b1;
    step();
    for (int k = 0; k < 10; k++) begin
      chk_ch("ch3 stop", 3, k, "1111000000", "1000000000", "1111111100");
      en[3] = (k < 1);
      step();
    end

    // ch3 again, en dropped at cnt=1 and re-raised at cnt=5: no gap
    en[3] = 1'b1;
    step();
    for (int k = 0; k < 16; k++) begin
      chk_ch("ch3 resume", 3, k, "1111000011110000", "1000000010000000", "1111111111111111");
      en[3] = !((k >= 1) && (k <= 4));
      step();
    end

    // ch1 invalid divisors 0 then 1 while running, then recovery with 2
    wait_tick(1);
    for (int k = 0; k < 13; k++) begin
      chk_ch("ch1 invalid", 1, k, "1110000000101", "1000000000101", "1111100000111");
      load[1] = (k == 0) || (k == 1) || (k == 8);
      set_div(1, (k == 0) ? 8'd0 : ((k == 1) ? 8'd1 : 8'd2));
      step();
    end
    load[1] = 1'b0;

    // Reset mid-period with all channels enabled
    en = '1;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    check("mid rst clk_out", 32'(clk_out), 32'd0);
    check("mid rst tick",    32'(tick),    32'd0);
    check("mid rst active",  32'(active),  32'd0);
    rst = 1'b0;
    step();
    check("restart0 clk_out", 32'(clk_out), 32'hF);
    check("restart0 tick",    32'(tick),    32'hF);
    check("restart0 active",  32'(active),  32'hF);
    step();
    check("restart1 clk_out", 32'(clk_out), 32'h0);
    check("restart1 tick",    32'(tick),    32'h0);
    check("restart1 active",  32'(active),  32'hF);
    step();
    check("restart2 clk_out", 32'(clk_out), 32'hF);
    check("restart2 tick",    32'(tick),    32'hF);
    check("restart2 active",  32'(active),  32'hF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
